// File: rtl/sprite_feeder_pkg.sv
// Shared types for the per-scanline sprite loader: OAM entry layout, the
// record pushed into the sprite_unit chain, and the loader FSM states.
package sprite_feeder_pkg;

    localparam int PAT_W      = 128;
    localparam int TILE_W     = 8;
    localparam int SROW_W     = 5;
    localparam int PAT_ADDR_W = TILE_W + SROW_W;

    // Sprite height is (h+1)*8 rows, so at most 32 rows fit in a 5-bit sprite_row.
    typedef struct packed {
        logic [TILE_W-1:0] tile;
        logic [7:0]        y;
        logic [7:0]        x;
        logic [1:0]        h;
        logic [1:0]        width;
        logic [3:0]        palette;
        logic              prio;
        logic              y_mirror;
        logic              x_mirror;
    } sprite_conf_t;

    typedef struct packed {
        sprite_conf_t      conf;
        logic [PAT_W-1:0]  pat;
    } sprite_reg_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_OAM_RD,
        S_OAM_CHK,
        S_PAT_RD,
        S_PUSH,
        S_DONE
    } feed_state_t;

endpackage

// File: rtl/sprite_feeder_row_hit.sv
// Vertical hit test for one OAM entry against a scanline, plus the pattern
// row to fetch (vertical mirror applied here; horizontal mirror is downstream).
module sprite_row_hit
    import sprite_feeder_pkg::*;
(
    input  sprite_conf_t       conf,
    input  logic [7:0]         row,
    output logic               hit,
    output logic [SROW_W-1:0]  sprite_row
);

    logic [8:0]        dy;
    logic [8:0]        span;
    logic [SROW_W-1:0] mrow;

    always_comb begin
        dy   = {1'b0, row} - {1'b0, conf.y};
        span = {3'b000, ({1'b0, conf.h} + 3'd1), 3'b000};
        hit  = (row >= conf.y) && (dy < span);
        // span[4:0] wraps to 0 for 32-row sprites, which still yields 31-dy mod 32.
        mrow = span[SROW_W-1:0] - SROW_W'(1) - dy[SROW_W-1:0];
        sprite_row = conf.y_mirror ? mrow : dy[SROW_W-1:0];
    end

endmodule

// File: rtl/sprite_feeder.sv
// Per-scanline sprite loader: on start, clears the sprite_unit chain, scans OAM
// in index order and pushes {conf, pattern row} for each sprite hitting the row.
//   state     | meaning
//   S_IDLE    | waiting for start
//   S_CLEAR   | one-cycle chain_clear pulse
//   S_OAM_RD  | present OAM address idx
//   S_OAM_CHK | OAM data valid; latch conf, hit test
//   S_PAT_RD  | pattern address presented
//   S_PUSH    | out_valid held until out_ack
//   S_DONE    | scan finished; busy drops next cycle
module sprite_feeder
    import sprite_feeder_pkg::*;
#(
    parameter int NUM_SPRITES = 64,
    parameter int NUM_UNITS   = 16
) (
    input  logic                            clock,
    input  logic                            reset_l,
    input  logic                            start,
    input  logic [7:0]                      row,
    output logic                            busy,
    output logic                            overflow,
    output logic                            chain_clear,
    output logic [$clog2(NUM_SPRITES)-1:0]  oam_addr,
    input  sprite_conf_t                    oam_data,
    output logic [PAT_ADDR_W-1:0]           pat_addr,
    input  logic [PAT_W-1:0]                pat_data,
    output sprite_reg_t                     out,
    output logic                            out_valid,
    input  logic                            out_ack
);

    localparam int IDX_W = $clog2(NUM_SPRITES);
    localparam int CNT_W = $clog2(NUM_UNITS + 1);

    feed_state_t             state_q, state_d;
    logic [7:0]              row_q, row_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    overflow_q, overflow_d;
    sprite_conf_t            conf_q, conf_d;
    logic [PAT_ADDR_W-1:0]   pat_addr_q, pat_addr_d;

    logic                    hit;
    logic [SROW_W-1:0]       sprite_row;
    logic                    last_idx;

    sprite_row_hit u_row_hit (
        .conf       (oam_data),
        .row        (row_q),
        .hit        (hit),
        .sprite_row (sprite_row)
    );

    assign last_idx = (idx_q == IDX_W'(NUM_SPRITES - 1));

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        idx_d      = idx_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        conf_d     = conf_q;
        pat_addr_d = pat_addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    row_d      = row;
                    idx_d      = '0;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR:  state_d = S_OAM_RD;
            S_OAM_RD: state_d = S_OAM_CHK;
            S_OAM_CHK: begin
                conf_d = oam_data;
                if (hit) begin
                    if (count_q == CNT_W'(NUM_UNITS)) begin
                        overflow_d = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        pat_addr_d = {oam_data.tile, sprite_row};
                        state_d    = S_PAT_RD;
                    end
                end else if (last_idx) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_OAM_RD;
                end
            end
            S_PAT_RD: state_d = S_PUSH;
            S_PUSH: begin
                if (out_ack) begin
                    count_d = count_q + CNT_W'(1);
                    if (last_idx) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_OAM_RD;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_l) begin
            state_q    <= S_IDLE;
            row_q      <= '0;
            idx_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            conf_q     <= '0;
            pat_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            idx_q      <= idx_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            conf_q     <= conf_d;
            pat_addr_q <= pat_addr_d;
        end
    end

    // pat_addr_q is held through PUSH, so the pattern memory keeps returning
    // the same row and out stays stable for the whole ack wait.
    assign busy        = (state_q != S_IDLE);
    assign chain_clear = (state_q == S_CLEAR);
    assign out_valid   = (state_q == S_PUSH);
    assign out         = out_valid ? sprite_reg_t'({conf_q, pat_data}) : '0;
    assign oam_addr    = idx_q;
    assign pat_addr    = pat_addr_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_sprite_feeder.sv
// Randomised and directed bench for sprite_feeder with an OAM/pattern memory
// model, a scanline reference model and a push scoreboard.
module tb_sprite_feeder;
    import sprite_feeder_pkg::*;

    logic              clock;
    logic              reset_l;
    logic              start;
    logic [7:0]        row;
    logic              busy;
    logic              overflow;
    logic              chain_clear;
    logic [5:0]        oam_addr;
    sprite_conf_t      oam_data;
    logic [12:0]       pat_addr;
    logic [PAT_W-1:0]  pat_data;
    sprite_reg_t       dout;
    logic              out_valid;
    logic              out_ack;

    sprite_feeder #(.NUM_SPRITES(64), .NUM_UNITS(16)) dut (
        .clock       (clock),
        .reset_l     (reset_l),
        .start       (start),
        .row         (row),
        .busy        (busy),
        .overflow    (overflow),
        .chain_clear (chain_clear),
        .oam_addr    (oam_addr),
        .oam_data    (oam_data),
        .pat_addr    (pat_addr),
        .pat_data    (pat_data),
        .out         (dout),
        .out_valid   (out_valid),
        .out_ack     (out_ack)
    );

    int checks = 0;
    int errors = 0;

    sprite_conf_t oam [64];
    sprite_reg_t  exp_q [$];
    logic         exp_ovf;
    int           clr_cnt = 0;
    int           max_oam = 0;
    int           ack_mode = 0;
    int           stall_left = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [PAT_W-1:0] pat_fn(input logic [12:0] a);
        logic [31:0] w;
        w = {19'd0, a} * 32'h9E37_79B1;
        return {w, ~w, w ^ 32'h5A5A_5A5A, {19'd0, a}};
    endfunction

    always @(posedge clock) begin
        oam_data <= oam[oam_addr];
        pat_data <= pat_fn(pat_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, req);
        end
    endtask

    // Reference: walk OAM in order, collect rows covered by each sprite span.
    function automatic void model(input logic [7:0] r);
        int hits = 0;
        exp_ovf = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            int top  = int'(oam[i].y);
            int rows = (int'(oam[i].h) + 1) * 8;
            int rr   = int'(r);
            if (rr >= top && rr < top + rows) begin
                int srow;
                logic [4:0] s5;
                sprite_reg_t e;
                if (hits == 16) begin
                    exp_ovf = 1'b1;
                    break;
                end
                srow = oam[i].y_mirror ? (rows - 1 - (rr - top)) : (rr - top);
                s5 = 5'(srow);
                e.conf = oam[i];
                e.pat  = pat_fn({oam[i].tile, s5});
                exp_q.push_back(e);
                hits++;
            end
        end
    endfunction

    // Scoreboard monitor: one expected record per accepted push.
    initial begin
        forever begin
            @(negedge clock);
            if (chain_clear) clr_cnt++;
            if (busy && int'(oam_addr) > max_oam) max_oam = int'(oam_addr);
            if (reset_l && out_valid && out_ack) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL push_unexpected actual %h required none", dout);
                end else begin
                    sprite_reg_t e;
                    e = exp_q.pop_front();
                    if (dout !== e) begin
                        errors++;
                        $display("FAIL push_data actual %h required %h", dout, e);
                    end
                end
            end
        end
    end

    initial begin
        out_ack = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ack_mode)
                0: out_ack = 1'b1;
                1: out_ack = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && stall_left > 0) begin
                        out_ack = 1'b0;
                        stall_left--;
                    end else begin
                        out_ack = 1'b1;
                    end
                end
                default: out_ack = 1'b0;
            endcase
        end
    end

    function automatic sprite_conf_t blank();
        sprite_conf_t c;
        c = '0;
        c.y = 8'd200;
        c.tile = 8'hEE;
        return c;
    endfunction

    function automatic sprite_conf_t mk(input logic [7:0] y, input logic [1:0] h,
                                        input logic ym, input logic [7:0] tile);
        sprite_conf_t c;
        logic [63:0] rnd;
        rnd = {$urandom(), $urandom()};
        c = rnd[$bits(sprite_conf_t)-1:0];
        c.y = y;
        c.h = h;
        c.y_mirror = ym;
        c.tile = tile;
        return c;
    endfunction

    task automatic clear_oam();
        for (int i = 0; i < 64; i++) oam[i] = blank();
    endtask

    task automatic run_row(input logic [7:0] r, input bit poke);
        int clr0;
        int cyc;
        model(r);
        clr0 = clr_cnt;
        max_oam = 0;
        @(negedge clock);
        start = 1'b1;
        row = r;
        @(negedge clock);
        start = 1'b0;
        row = 8'hA5;
        check("busy_after_start", 64'(busy), 64'd1);
        check("clear_pulse", 64'(chain_clear), 64'd1);
        @(negedge clock);
        check("clear_one_cycle", 64'(chain_clear), 64'd0);
        if (poke) begin
            repeat (5) @(negedge clock);
            start = 1'b1;
            row = r + 8'd1;
            @(negedge clock);
            start = 1'b0;
        end
        cyc = 0;
        while (busy && cyc < 5000) begin
            @(negedge clock);
            cyc++;
        end
        check("row_timeout", 64'(busy), 64'd0);
        check("pushes_left", 64'(exp_q.size()), 64'd0);
        check("overflow", 64'(overflow), 64'(exp_ovf));
        check("clear_count", 64'(clr_cnt - clr0), 64'd1);
    endtask

    task automatic pat_watch(input logic [12:0] req);
        int cyc = 0;
        while (!out_valid && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("pat_addr", 64'(pat_addr), 64'(req));
    endtask

    task automatic stall_watch();
        sprite_reg_t snap;
        logic [5:0]  snap_addr;
        int cyc = 0;
        while (!out_valid && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("stall_first_valid", 64'(out_valid), 64'd1);
        snap = dout;
        snap_addr = oam_addr;
        check("stall_ack_low", 64'(out_ack), 64'd0);
        repeat (6) begin
            @(negedge clock);
            checks++;
            if (dout !== snap || !out_valid || out_ack || oam_addr !== snap_addr) begin
                errors++;
                $display("FAIL stall_stable actual v=%0d ack=%0d a=%0d required v=1 ack=0 a=%0d",
                         out_valid, out_ack, oam_addr, snap_addr);
            end
        end
    endtask

    initial begin
        reset_l = 1'b0;
        start = 1'b0;
        row = 8'd0;
        clear_oam();
        repeat (3) @(negedge clock);
        reset_l = 1'b1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_clear", 64'(chain_clear), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_out", 64'(dout == '0), 64'd1);
        check("rst_oam_addr", 64'(oam_addr), 64'd0);
        check("rst_pat_addr", 64'(pat_addr), 64'd0);

        // Single sprite at index 5, ack tied high.
        ack_mode = 0;
        clear_oam();
        oam[5] = mk(8'd10, 2'd0, 1'b0, 8'h3C);
        fork
            run_row(8'd13, 1'b0);
            pat_watch({8'h3C, 5'd3});
        join
        check("single_max_oam", 64'(max_oam), 64'd63);

        // Vertical mirror on a 16-row sprite.
        clear_oam();
        oam[3] = mk(8'd100, 2'd1, 1'b1, 8'h71);
        fork
            run_row(8'd102, 1'b0);
            pat_watch({8'h71, 5'd13});
        join

        // Twenty hits: only the first sixteen are pushed, scan stops at the 17th.
        clear_oam();
        for (int i = 0; i < 20; i++) oam[i] = mk(8'(43 + (i % 8)), 2'(i % 4), 1'(i % 2), 8'(i));
        run_row(8'd50, 1'b0);
        check("ovf_stop_idx", 64'(max_oam), 64'd16);

        // Seven-cycle stall on the first push.
        clear_oam();
        oam[2] = mk(8'd60, 2'd2, 1'b0, 8'h12);
        oam[9] = mk(8'd64, 2'd0, 1'b1, 8'h34);
        stall_left = 7;
        ack_mode = 2;
        fork
            run_row(8'd66, 1'b0);
            stall_watch();
        join

        // Bottom-edge boundaries and start while busy.
        ack_mode = 0;
        clear_oam();
        oam[7] = mk(8'd250, 2'd1, 1'b0, 8'h55);
        fork
            run_row(8'd255, 1'b1);
            pat_watch({8'h55, 5'd5});
        join
        run_row(8'd208, 1'b0);

        // Reset while a push is pending.
        ack_mode = 3;
        clear_oam();
        oam[1] = mk(8'd20, 2'd0, 1'b0, 8'h09);
        @(negedge clock);
        start = 1'b1;
        row = 8'd22;
        @(negedge clock);
        start = 1'b0;
        begin
            int cyc = 0;
            while (!out_valid && cyc < 500) begin
                @(negedge clock);
                cyc++;
            end
        end
        check("pre_reset_valid", 64'(out_valid), 64'd1);
        reset_l = 1'b0;
        @(negedge clock);
        reset_l = 1'b1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        ack_mode = 0;
        run_row(8'd22, 1'b0);

        // Random OAM contents and random ack.
        ack_mode = 1;
        for (int k = 0; k < 8; k++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            for (int i = 0; i < 64; i++) begin
                logic [7:0] y;
                y = (k >= 6) ? 8'(int'(r) - int'($urandom_range(0, 7)))
                             : 8'($urandom_range(0, 255));
                oam[i] = mk(y, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                            8'($urandom_range(0, 255)));
            end
            run_row(r, k == 3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
